lsu_byte_master: RTL

- Load/store initiator between the pipeline MEM stage and the byte-addressed data memory (8-bit port, little-endian).
- Accepts one load or store request of 1/2/4/8 bytes and serialises it into one byte access per cycle.
- Returns a sign- or zero-extended 64-bit load result, or a store acknowledge, with a single-cycle response pulse.
- Drives the pipeline stall via busy.

---
 rtl/lsu_byte_master.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/lsu_byte_master.sv
// lsu_byte_master
//   Load/store initiator between the pipeline MEM stage and an 8-bit,
//   little-endian, byte-addressed data memory. It accepts one load or store
//   of 1/2/4/8 bytes, performs one byte access per cycle, and returns a
//   single-cycle response. A load returns sign- or zero-extended data. A store
//   returns an acknowledge with zero data.
//
// Ports
//   clk, reset      clock; synchronous active-low reset
//   req_*           request: valid/ready, write, size, unsigned, addr, wdata
//   resp_*          one-cycle completion pulse with rdata and err
//   busy            stall request to the pipeline (high whenever not IDLE)
//   mem_*           byte memory port: addr, wdata, we, re, rdata (comb read)
//   dbg_state       current FSM state (0 IDLE, 1 XFER, 2 RESP)
//
// Handshake: a request transfers on a posedge where req_valid && req_ready.
// req_ready is high only in IDLE. The block holds no queue, so requests
// presented while busy are ignored rather than held. resp_valid is a
// single-cycle pulse and has no ready input.
module lsu_byte_master #(
  parameter int ADDR_W    = 64,
  parameter int MEM_BYTES = 1234
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [63:0]       req_wdata,
  output logic              resp_valid,
  output logic [63:0]       resp_rdata,
  output logic              resp_err,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [7:0]        mem_rdata,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // The range check uses one extra bit so that addr + N cannot wrap.
  localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W+1)'(MEM_BYTES);

  state_e            state_q, state_d;
  logic [2:0]        k_q, k_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        size_q, size_d;
  logic              write_q, write_d;
  logic              unsigned_q, unsigned_d;
  logic [63:0]       wdata_q, wdata_d;
  logic [63:0]       data_q, data_d;

  logic              req_ready_q, req_ready_d;
  logic              resp_valid_q, resp_valid_d;
  logic [63:0]       resp_rdata_q, resp_rdata_d;
  logic              resp_err_q, resp_err_d;
  logic              busy_q, busy_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic              mem_we_q, mem_we_d;
  logic              mem_re_q, mem_re_d;

  // N-1 for a given size. It is the alignment mask and also the index of
  // the last byte.
  function automatic logic [2:0] size_mask(input logic [1:0] sz);
    case (sz)
      2'd0:    size_mask = 3'd0;
      2'd1:    size_mask = 3'd1;
      2'd2:    size_mask = 3'd3;
      default: size_mask = 3'd7;
    endcase
  endfunction

  // Extends the low 8N bits to 64. A double is returned raw.
  function automatic logic [63:0] extend(input logic [63:0] d,
                                         input logic [1:0]  sz,
                                         input logic        uns);
    case (sz)
      2'd0:    extend = {{56{d[7]  & ~uns}}, d[7:0]};
      2'd1:    extend = {{48{d[15] & ~uns}}, d[15:0]};
      2'd2:    extend = {{32{d[31] & ~uns}}, d[31:0]};
      default: extend = d;
    endcase
  endfunction

  logic [ADDR_W:0] req_end;
  logic            req_bad;
  logic [2:0]      k_next;

  always_comb begin
    req_end = {1'b0, req_addr} + (ADDR_W+1)'({1'b0, size_mask(req_size)} + 4'd1);
    req_bad = ((req_addr[2:0] & size_mask(req_size)) != 3'd0) || (req_end > MEM_LIMIT);
    k_next  = k_q + 3'd1;

    state_d      = state_q;
    k_d          = k_q;
    addr_d       = addr_q;
    size_d       = size_q;
    write_d      = write_q;
    unsigned_d   = unsigned_q;
    wdata_d      = wdata_q;
    data_d       = data_q;
    req_ready_d  = 1'b0;
    resp_valid_d = 1'b0;
    resp_rdata_d = 64'd0;
    resp_err_d   = 1'b0;
    busy_d       = 1'b1;
    mem_addr_d   = mem_addr_q;   // address holds outside XFER
    mem_wdata_d  = 8'd0;
    mem_we_d     = 1'b0;
    mem_re_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        req_ready_d = 1'b1;
        busy_d      = 1'b0;
        if (req_valid) begin
          addr_d      = req_addr;
          size_d      = req_size;
          write_d     = req_write;
          unsigned_d  = req_unsigned;
          wdata_d     = req_wdata;
          data_d      = 64'd0;
          k_d         = 3'd0;
          req_ready_d = 1'b0;
          busy_d      = 1'b1;
          if (req_bad) begin
            // Rejected requests skip memory entirely and respond next cycle.
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else begin
            state_d     = ST_XFER;
            mem_addr_d  = req_addr;
            mem_we_d    = req_write;
            mem_re_d    = ~req_write;
            mem_wdata_d = req_write ? req_wdata[7:0] : 8'd0;
          end
        end
      end

      ST_XFER: begin
        if (!write_q) data_d[{k_q, 3'b000} +: 8] = mem_rdata;
        if (k_q == size_mask(size_q)) begin
          state_d      = ST_RESP;
          resp_valid_d = 1'b1;
          // data_d already contains the last byte captured on this edge.
          resp_rdata_d = write_q ? 64'd0 : extend(data_d, size_q, unsigned_q);
        end else begin
          k_d         = k_next;
          mem_addr_d  = addr_q + ADDR_W'(k_next);
          mem_we_d    = write_q;
          mem_re_d    = ~write_q;
          mem_wdata_d = write_q ? wdata_q[{k_next, 3'b000} +: 8] : 8'd0;
        end
      end

      ST_RESP: begin
        state_d     = ST_IDLE;
        req_ready_d = 1'b1;
        busy_d      = 1'b0;
      end

      default: begin
        state_d     = ST_IDLE;
        req_ready_d = 1'b1;
        busy_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      k_q          <= 3'd0;
      addr_q       <= '0;
      size_q       <= 2'd0;
      write_q      <= 1'b0;
      unsigned_q   <= 1'b0;
      wdata_q      <= 64'd0;
      data_q       <= 64'd0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 64'd0;
      resp_err_q   <= 1'b0;
      busy_q       <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= 8'd0;
      mem_we_q     <= 1'b0;
      mem_re_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      addr_q       <= addr_d;
      size_q       <= size_d;
      write_q      <= write_d;
      unsigned_q   <= unsigned_d;
      wdata_q      <= wdata_d;
      data_q       <= data_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      busy_q       <= busy_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_we_q     <= mem_we_d;
      mem_re_q     <= mem_re_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign busy       = busy_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_we     = mem_we_q;
  assign mem_re     = mem_re_q;
  assign dbg_state  = state_q;

endmodule
